// File: rtl/fft_pkg.sv
// Shared FFT definitions: butterfly-stage FSM states and frame geometry helpers.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAIR = 2'd2
  } bfly_state_t;

  localparam int NUM_DEF  = 16;
  localparam int DATA_DEF = 512;

  // Beats per frame.
  function automatic int beat_count(input int data, input int num);
    return data / num;
  endfunction

  // Beats in the first (delay-line fill) half of a frame.
  function automatic int half_count(input int data, input int num);
    return (data / num) / 2;
  endfunction

endpackage

// File: rtl/valid_pipe.sv
// Fixed-latency shift pipeline for sideband valid/tag bits, with sync clear.
module valid_pipe #(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         pend
);

  logic [DEPTH:1][W-1:0] vld_pipe;

  // Shift one stage per cycle; clr empties every stage at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
    end else if (clr) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= din;
      for (int i = 2; i <= DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign dout = vld_pipe[DEPTH];
  assign pend = |vld_pipe;

endmodule

// File: rtl/bfly_stage_ctrl.sv
// Butterfly stage controller: first half of a frame fills the delay line,
// second half pairs delayed and live beats through the butterfly. Control only.
module bfly_stage_ctrl
  import fft_pkg::*;
#(
  parameter int NUM      = NUM_DEF,
  parameter int DATA     = DATA_DEF,
  parameter int BFLY_LAT = 2          // legal 1..8
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 flush,
  input  logic                                 valid_in,
  output logic                                 sr_write,
  output logic                                 sr_read,
  output logic                                 bfly_en,
  output logic                                 valid_out,
  output logic [$clog2(beat_count(DATA,NUM))-1:0] beat_idx,
  output logic                                 frame_done,
  output logic                                 busy
);

  localparam int COUNT = beat_count(DATA, NUM);
  localparam int HALF  = half_count(DATA, NUM);
  localparam int IW    = $clog2(COUNT);
  localparam logic [IW-1:0] HALF_LAST = IW'(HALF - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(COUNT - 1);

  bfly_state_t   state;
  logic [IW-1:0] idx;
  logic          accept;
  logic          last_beat;
  logic [1:0]    pipe_dout;
  logic          pipe_pend;

  // Frame sequencing: IDLE/FILL count the fill half, PAIR the pairing half.
  // The wrap back to FILL is decided by the last beat itself, so a beat in
  // the very next cycle starts the following frame without a bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      idx   <= '0;
    end else if (flush) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE, FILL: begin
          if (valid_in) begin
            idx   <= idx + 1'b1;
            state <= (idx == HALF_LAST) ? PAIR : FILL;
          end else if (state == FILL && idx == '0) begin
            state <= IDLE;
          end
        end
        PAIR: begin
          if (valid_in) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= FILL;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Strobes follow the live beat; flush drops it and reset silences everything.
  always_comb begin
    accept    = valid_in & ~flush & rstn;
    sr_write  = accept & (state != PAIR);
    sr_read   = accept & (state == PAIR);
    bfly_en   = sr_read;
    last_beat = bfly_en & (idx == LAST_IDX);
  end

  valid_pipe #(
    .W     (2),
    .DEPTH (BFLY_LAT)
  ) u_valid_pipe (
    .clk  (clk),
    .rstn (rstn),
    .clr  (flush),
    .din  ({last_beat, bfly_en}),
    .dout (pipe_dout),
    .pend (pipe_pend)
  );

  assign valid_out  = pipe_dout[0];
  assign frame_done = pipe_dout[1] & pipe_dout[0];
  assign beat_idx   = idx;
  assign busy       = (state != IDLE) | pipe_pend;

endmodule

// File: tb/tb_bfly_stage_ctrl.sv
// Scoreboard bench for bfly_stage_ctrl: strobes checked per beat against a
// frame counter model, butterfly outputs checked against a queue of due beats.
module tb_bfly_stage_ctrl;

  localparam int NUM   = 16;
  localparam int DATA  = 512;
  localparam int BL    = 2;
  localparam int COUNT = DATA / NUM;
  localparam int HALF  = COUNT / 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       flush = 1'b0;
  logic       valid_in = 1'b0;
  logic       sr_write, sr_read, bfly_en, valid_out, frame_done, busy;
  logic [4:0] beat_idx;

  bfly_stage_ctrl #(.NUM(NUM), .DATA(DATA), .BFLY_LAT(BL)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .valid_in   (valid_in),
    .sr_write   (sr_write),
    .sr_read    (sr_read),
    .bfly_en    (bfly_en),
    .valid_out  (valid_out),
    .beat_idx   (beat_idx),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    bit last;
  } exp_t;

  exp_t q[$];
  int   fd_t[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc_n = 0;
  int   m_idx = 0;
  bit   m_act = 0;
  int   vo_cnt = 0;
  int   fd_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc_n, obs, exp_v);
    end
  endtask

  // One clock of stimulus: check registered outputs, drive, check strobes, update model.
  task automatic cyc(input bit vin, input bit fl);
    exp_t e;
    bit   acc;
    @(negedge clk);
    chk("busy", busy, (m_act || q.size() > 0));
    if (valid_out) begin
      vo_cnt++;
      if (frame_done) begin
        fd_cnt++;
        fd_t.push_back(cyc_n);
      end
      if (q.size() == 0) chk("vo_spurious", 1, 0);
      else begin
        e = q.pop_front();
        chk("vo_time", cyc_n, e.due);
        chk("frame_done", frame_done, e.last);
      end
    end else begin
      chk("fd_without_vo", frame_done, 0);
      if (q.size() > 0 && q[0].due <= cyc_n) begin
        chk("vo_missing", 0, 1);
        void'(q.pop_front());
      end
    end
    valid_in = vin;
    flush    = fl;
    #1;
    acc = vin && !fl;
    chk("sr_write", sr_write, acc && m_idx < HALF);
    chk("sr_read",  sr_read,  acc && m_idx >= HALF);
    chk("bfly_en",  bfly_en,  acc && m_idx >= HALF);
    chk("beat_idx", beat_idx, m_idx);
    if (fl) begin
      m_idx = 0;
      m_act = 0;
      q.delete();
    end else if (acc) begin
      if (m_idx >= HALF) begin
        e.due  = cyc_n + BL;
        e.last = (m_idx == COUNT - 1);
        q.push_back(e);
      end
      m_idx = (m_idx + 1) % COUNT;
      m_act = 1;
    end else if (m_act && m_idx == 0) begin
      m_act = 0;
    end
    cyc_n++;
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic clr_counts();
    vo_cnt = 0;
    fd_cnt = 0;
    fd_t.delete();
  endtask

  // Hold reset with valid_in high; every output must stay quiet.
  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_outs", {sr_write, sr_read, bfly_en, valid_out, frame_done, busy}, 6'b0);
      chk("rst_idx", beat_idx, 0);
    end
    @(negedge clk);
    rstn     = 1'b1;
    valid_in = 1'b0;
    m_idx = 0;
    m_act = 0;
    q.delete();
    cyc_n++;
  endtask

  task automatic full_frame_checks(input string tag);
    chk({tag, "_vo_cnt"}, vo_cnt, HALF);
    chk({tag, "_fd_cnt"}, fd_cnt, 1);
  endtask

  initial begin
    valid_in = 1'b1;
    hold_reset(3);

    // Single frame, continuous beats.
    clr_counts();
    beats(COUNT);
    idle(BL + 3);
    full_frame_checks("single");

    // Three frames back to back: done pulses 32 cycles apart.
    clr_counts();
    beats(3 * COUNT);
    idle(BL + 3);
    chk("b2b_vo_cnt", vo_cnt, 3 * HALF);
    chk("b2b_fd_cnt", fd_cnt, 3);
    if (fd_t.size() == 3) begin
      chk("b2b_fd_gap0", fd_t[1] - fd_t[0], COUNT);
      chk("b2b_fd_gap1", fd_t[2] - fd_t[1], COUNT);
    end

    // Three-cycle gap at beat 10 in the fill half.
    clr_counts();
    beats(10);
    idle(3);
    chk("gap_fill_hold_idx", beat_idx, 10);
    beats(COUNT - 10);
    idle(BL + 3);
    full_frame_checks("gap_fill");

    // One-cycle gap at beat 20 in the pairing half.
    clr_counts();
    beats(20);
    idle(1);
    beats(COUNT - 20);
    idle(BL + 3);
    full_frame_checks("gap_pair");

    // Flush together with beat 24: frame abandoned, nothing more comes out.
    clr_counts();
    beats(24);
    cyc(1'b1, 1'b1);
    clr_counts();
    idle(BL + 3);
    chk("flush_vo_cnt", vo_cnt, 0);
    chk("flush_fd_cnt", fd_cnt, 0);
    chk("flush_idx", beat_idx, 0);

    // Flush while idle is a no-op.
    cyc(1'b0, 1'b1);
    idle(2);
    chk("flush_idle_busy", busy, 0);

    // Reset at beat 5, then a fresh frame behaves like the first one.
    beats(5);
    @(negedge clk);
    valid_in = 1'b1;
    rstn     = 1'b0;
    #1;
    chk("async_rst_idx", beat_idx, 0);
    chk("async_rst_wr", sr_write, 0);
    cyc_n++;
    hold_reset(2);
    clr_counts();
    beats(COUNT);
    idle(BL + 3);
    full_frame_checks("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bfly_stage_ctrl.md
BFLY_STAGE_CTRL -- requirements
Module: bfly_stage_ctrl

Interface
REQ-001 Parameter NUM, default 16: parallel lanes per beat.
REQ-002 Parameter DATA, default 512: samples per frame.
REQ-003 Parameter BFLY_LAT, default 2: butterfly datapath latency in cycles, legal range 1..8.
REQ-004 Derived constants: COUNT = DATA/NUM (32 beats per frame); HALF = COUNT/2 (16).
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port rstn, input, 1: reset, asynchronous, active-low.
REQ-007 Port flush, input, 1: synchronous abort of the current frame.
REQ-008 Port valid_in, input, 1: upstream beat valid, one beat of NUM samples per cycle.
REQ-009 Port sr_write, output, 1: delay-line write strobe.
REQ-010 Port sr_read, output, 1: delay-line read strobe.
REQ-011 Port bfly_en, output, 1: butterfly compute enable.
REQ-012 Port valid_out, output, 1: butterfly output beat valid.
REQ-013 Port beat_idx, output, $clog2(COUNT): index of the accepted beat within the frame.
REQ-014 Port frame_done, output, 1: one-cycle pulse coinciding with the last valid_out beat of a frame.
REQ-015 Port busy, output, 1: high whenever state is not IDLE or any pipeline valid is pending.

Function
REQ-016 The FSM shall have three states: IDLE, FILL and PAIR.
REQ-017 IDLE->FILL on valid_in; the first beat is accepted in the same cycle, sr_write=1 and beat_idx=0.
REQ-018 In FILL, each valid_in beat shall assert sr_write and increment beat_idx; the beat at index HALF-1 moves the FSM to PAIR.
REQ-019 In PAIR, each valid_in beat shall assert sr_read and bfly_en and increment beat_idx; the beat at index COUNT-1 wraps beat_idx to 0.
REQ-020 At that wrap, the next state shall be FILL; a valid_in in the following cycle is accepted with no bubble.
REQ-021 The FSM shall not depend on valid_in at the wrap cycle to choose its next state.
REQ-022 FILL with no valid_in for a whole frame shall be harmless; beat_idx=0 in FILL is observably equivalent to IDLE except for busy.
REQ-023 FILL->IDLE when beat_idx=0 and valid_in=0.
REQ-024 A valid_in gap mid-frame shall stall: beat_idx and state hold, and sr_write, sr_read and bfly_en are all 0 that cycle.
REQ-025 sr_write, sr_read and bfly_en shall be combinational from state and valid_in; sr_write and sr_read are never high together.
REQ-026 valid_out shall be bfly_en delayed exactly BFLY_LAT cycles through a shift pipeline; gaps propagate unchanged.
REQ-027 A second pipeline bit, last-beat, shall track the PAIR beat with index COUNT-1; frame_done equals its delayed value ANDed with valid_out.
REQ-028 flush shall force state IDLE and beat_idx 0, and clear both pipelines next cycle; flush has priority over a simultaneous valid_in, which is dropped.
REQ-029 flush in IDLE with empty pipelines shall have no effect.
REQ-030 busy shall fall the cycle after the last pending valid_out leaves the pipeline.

Reset
REQ-031 On rstn low, state shall become IDLE and beat_idx 0 asynchronously.
REQ-032 On rstn low, both pipelines shall clear asynchronously.
REQ-033 During reset, valid_out, frame_done, busy, sr_write, sr_read and bfly_en shall be 0.
REQ-034 Reset mid-frame shall discard the partial frame; the first beat after rstn release starts a new frame at index 0.

Structure
REQ-035 The state enum and the COUNT/HALF derivation shall live in shared package fft_pkg, which the datapath also imports.
REQ-036 The BFLY_LAT delay shall be one sub-module, valid_pipe, parameterised on width and depth and instantiated 2 bits wide (valid, last).
REQ-037 No datapath signals shall pass through this block.

Verification
REQ-038 Continuous 32 beats: sr_write high beats 0-15, sr_read/bfly_en high beats 16-31, valid_out high cycles 16+BFLY_LAT..31+BFLY_LAT, frame_done at 31+BFLY_LAT.
REQ-039 Back-to-back 3 frames, 96 beats: no bubble; frame_done pulses exactly 3 times, 32 cycles apart.
REQ-040 valid_in low at beat 10 for 3 cycles: beat_idx holds 10, strobes are 0, and the frame completes 3 cycles late with 16 valid_out beats.
REQ-041 Gap at beat 20 in PAIR: valid_out shows a matching 1-cycle hole BFLY_LAT cycles later, and the total valid_out count is 16.
REQ-042 flush with valid_in at beat 24: the next cycle is IDLE, no further valid_out or frame_done appears, and busy=0.
REQ-043 rstn asserted at beat 5, then a frame restarted: outputs are 0 during reset, and the new frame behaves exactly as in REQ-038.
